// File: rtl/gcd_binary_core_if.sv
// Host-side request/result bundle for the binary GCD core.
interface gcd_binary_core_if #(
  parameter int WIDTH = 1279,
  parameter int CNT_W = 12
);
  logic             start;
  logic             constant_time;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd;
  logic [CNT_W-1:0] cycle_count;

  modport master (output start, constant_time, A, B,
                  input  busy, done, gcd, cycle_count);
  modport slave  (input  start, constant_time, A, B,
                  output busy, done, gcd, cycle_count);
endinterface

// File: rtl/gcd_binary_core.sv
// Iterative binary (Stein) GCD: one reduction step per enabled clock,
// optionally padded to a fixed MAX_ITER steps for data-independent timing.
module gcd_binary_core #(
  parameter int WIDTH    = 1279,
  parameter int MAX_ITER = 2*WIDTH,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  gcd_binary_core_if.slave  bus
);
  localparam int KW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b, gcd_q;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] cnt, cycle_count_q;
  logic             ct, busy_q, done_q;

  logic             term, finish;
  logic [WIDTH-1:0] a_minus_b, b_minus_a;

  assign term      = (a == '0) || (b == '0);
  assign finish    = ct ? (cnt == CNT_W'(MAX_ITER)) : term;
  // Only the difference selected by the a>=b compare is ever stored, so no underflow.
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a             <= '0;
      b             <= '0;
      k             <= '0;
      cnt           <= '0;
      ct            <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      gcd_q         <= '0;
      cycle_count_q <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (bus.start) begin
          a             <= bus.A;
          b             <= bus.B;
          k             <= '0;
          cnt           <= '0;
          ct            <= bus.constant_time;
          busy_q        <= 1'b1;
          done_q        <= 1'b0;
          gcd_q         <= '0;
          cycle_count_q <= '0;
          state         <= RUN;
        end
        RUN: begin
          if (finish) begin
            gcd_q         <= (a | b) << k;
            cycle_count_q <= cnt;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // term here implies constant mode: idle-step until the budget is used up.
            if (!term) begin
              if (!a[0] && !b[0]) begin
                a <= a >> 1;
                b <= b >> 1;
                k <= k + KW'(1);
              end else if (!a[0]) begin
                a <= a >> 1;
              end else if (!b[0]) begin
                b <= b >> 1;
              end else if (a >= b) begin
                a <= a_minus_b >> 1;
              end else begin
                b <= b_minus_a >> 1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.gcd         = gcd_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: doc/gcd_binary_core.md
Name: gcd_binary_core

Overview:
- Parametrised, functional successor to the fixed-latency GCD stub: an iterative binary (Stein) GCD engine.
- Performs one reduction step per enabled clock, with an optional constant-time mode that always runs exactly MAX_ITER steps.
- Sits behind the GCD wrapper in place of the stub.
- Exposes start/busy/done and a cycle count for the host and the debug path.

Parameters:
- WIDTH, 1279, operand and result width in bits.
- MAX_ITER, 2*WIDTH, step count in constant-time mode. Must be >= 2*WIDTH; this is also the worst-case step bound for variable-time mode.
- CNT_W, 12, step-counter and cycle_count width. Requires 2**CNT_W > MAX_ITER.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  global enable. When 0, all state, including outputs, holds.
- start  in  1  request. Accepted only on an enabled edge in IDLE.
- constant_time  in  1  sampled at accept. 1 = fixed MAX_ITER-step run.
- A  in  WIDTH  operand, sampled at accept.
- B  in  WIDTH  operand, sampled at accept.
- busy  out  1  high from the accept edge until the finish edge.
- done  out  1  sticky result-valid flag.
- gcd  out  WIDTH  result register.
- cycle_count  out  CNT_W  number of RUN steps taken by the last operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, gcd=0, cycle_count=0. Internal a, b, k, cnt and the ct flag are all 0.
- Reset asserted mid-operation aborts immediately to these values; no partial result is visible.
- Every transition below occurs only on a rising clk edge with clk_en=1. With clk_en=0, nothing changes, including acceptance of start.
- IDLE:
  - If start=1: a<=A, b<=B, k<=0, cnt<=0, ct<=constant_time.
  - Also busy<=1, done<=0, gcd<=0, cycle_count<=0; go to RUN.
  - start while busy is ignored.
- RUN: term = (a==0)||(b==0). Each enabled edge does exactly one of:
  - Finish. Condition: variable mode with term=1, or constant mode with cnt==MAX_ITER.
    - gcd<=(a|b)<<k, cycle_count<=cnt, done<=1, busy<=0; go to IDLE.
  - Hold. Condition: constant mode, term=1, cnt<MAX_ITER.
    - a, b, k unchanged; cnt<=cnt+1.
  - Step. Condition: term=0. Priority order, with cnt<=cnt+1 in every case:
    1. a and b both even: a>>=1, b>>=1, k+=1.
    2. Only a even: a>>=1.
    3. Only b even: b>>=1.
    4. Both odd, a>=b: a<=(a-b)>>1.
    5. Both odd, a<b: b<=(b-a)>>1.
- Width rules:
  - Subtraction is unsigned WIDTH-bit; the guarded compare means it never underflows.
  - k needs $clog2(WIDTH+1) bits.
  - (a|b)<<k never exceeds WIDTH bits.
- Latency:
  - Accept edge E0; finish at edge E(cycle_count+1), counting enabled edges only.
  - Variable mode: cycle_count <= 2*WIDTH.
  - Constant mode: cycle_count == MAX_ITER always, independent of data.
- done:
  - Stays 1 until the next accepted start; gcd and cycle_count also hold until then.
  - start on the same edge that done is high and state is IDLE is accepted. That edge clears done.
- Degenerate operands:
  - gcd(0,0)=0.
  - gcd(0,x)=gcd(x,0)=x; in variable mode these finish with cycle_count=0.
- Simultaneous events:
  - start is irrelevant in RUN, including on the finish edge.
  - A new start can only be accepted on the edge after finish.

Test Plan:
1. WIDTH=16, variable mode, A=48, B=18, clk_en=1 -> steps (24,9,k1),(12,9),(6,9),(3,9),(3,3),(0,3). Finish at E7 with gcd=6, cycle_count=6, busy high E0..E7, done=1 from E7.
2. WIDTH=16, constant_time=1, A=48, B=18 -> gcd=6, cycle_count=32, finish at E33. Repeat with A=1, B=65535 -> same finish edge, gcd=1.
3. A=0, B=0 -> gcd=0, cycle_count=0, done at E1. A=0, B=5 -> gcd=5 at E1. A=65535, B=65535 -> gcd=65535.
4. Toggle clk_en (1 of every 3 edges) during case 1 -> identical gcd and cycle_count, finishing on the 7th enabled edge. start pulsed with clk_en=0 in IDLE -> not accepted.
5. Pulse start with new operands while busy -> ignored, first result unchanged. Then start on the edge after done -> done cleared, new result correct.
6. Deassert rst_n mid-RUN (async, between edges) -> busy, done, gcd, cycle_count go to 0 immediately. After release, a new start computes correctly.
